// File: rtl/mac_dot_pkg.sv
// Shared types and defaults for the streaming dot-product MAC and its requantizer.
package mac_dot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_OUT_WIDTH  = 32;
  localparam int unsigned DEF_SHIFT      = 8;
  localparam int unsigned DEF_MAX_LEN    = 256;
  localparam int unsigned DEF_CNT_WIDTH  = 9;

  // Half-LSB of the post-shift result; zero when no shift is applied.
  function automatic logic [63:0] rnd_const(input int unsigned shift);
    return (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
  endfunction

endpackage

// File: rtl/mac_dot_stream_if.sv
// Operand-in / result-out stream bundle for mac_dot_stream (slave = engine side).
interface mac_dot_stream_if
  import mac_dot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_a;
  logic signed [DATA_WIDTH-1:0] in_b;
  logic                         in_last;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic signed [OUT_WIDTH-1:0]  out_acc;
  logic        [CNT_WIDTH-1:0]  out_beats;
  logic                         out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_acc, out_beats, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_acc, out_beats, out_ovf
  );

endinterface

// File: rtl/mac_dot_requant.sv
// Round-half-up, arithmetic right shift and narrow of an accumulator value.
// MAC_DOT_SAT_EN selects clamping on narrow; otherwise plain truncation.
module mac_dot_requant
  import mac_dot_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SHIFT      = DEF_SHIFT
) (
  input  logic signed [OUT_WIDTH-1:0]  i_sum,
  output logic signed [DATA_WIDTH-1:0] o_data
);

  localparam int unsigned EW = OUT_WIDTH + 1;

  logic signed [EW-1:0] w_ext;
  logic signed [EW-1:0] w_rnd;

  // One guard bit so the rounding add cannot wrap at the positive extreme.
  assign w_ext = {i_sum[OUT_WIDTH-1], i_sum};
  assign w_rnd = w_ext + $signed(EW'(rnd_const(SHIFT)));

`ifdef MAC_DOT_SAT_EN
  localparam logic signed [EW-1:0] SAT_MAX = EW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [EW-1:0] w_shr;

  assign w_shr = w_rnd >>> SHIFT;

  always_comb begin
    o_data = w_shr[DATA_WIDTH-1:0];
    if (w_shr > SAT_MAX) begin
      o_data = DATA_WIDTH'(SAT_MAX);
    end else if (w_shr < SAT_MIN) begin
      o_data = DATA_WIDTH'(SAT_MIN);
    end
  end
`else
  assign o_data = DATA_WIDTH'(w_rnd >>> SHIFT);
`endif

endmodule

// File: rtl/mac_dot_stream.sv
// Streaming signed dot-product engine: accumulates a*b per vector, emits raw and
// requantized sums. Optional saturation on narrow via MAC_DOT_SAT_EN.
module mac_dot_stream
  import mac_dot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int unsigned SHIFT      = DEF_SHIFT,
  parameter int unsigned MAX_LEN    = DEF_MAX_LEN,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  mac_dot_stream_if.slave bus
);

  state_t r_state;
  state_t w_state_nxt;

  logic signed [OUT_WIDTH-1:0]    r_acc;
  logic        [CNT_WIDTH-1:0]    r_cnt;
  logic                           r_out_valid;
  logic signed [DATA_WIDTH-1:0]   r_out_data;
  logic signed [OUT_WIDTH-1:0]    r_out_acc;
  logic        [CNT_WIDTH-1:0]    r_out_beats;
  logic                           r_out_ovf;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [OUT_WIDTH-1:0]    w_prod_ext;
  logic signed [OUT_WIDTH-1:0]    w_sum;
  logic        [CNT_WIDTH-1:0]    w_cnt_nxt;
  logic signed [DATA_WIDTH-1:0]   w_req;
  logic                           w_accept;
  logic                           w_at_max;
  logic                           w_term;
  logic                           w_out_hs;

  assign bus.in_ready  = (r_state != HOLD);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_acc   = r_out_acc;
  assign bus.out_beats = r_out_beats;
  assign bus.out_ovf   = r_out_ovf;

  assign w_prod     = (2*DATA_WIDTH)'(bus.in_a) * (2*DATA_WIDTH)'(bus.in_b);
  assign w_prod_ext = OUT_WIDTH'(w_prod);

  // IDLE substitutes zero for the stale accumulator so no explicit clear is needed.
  always_comb begin
    w_accept  = bus.in_valid & bus.in_ready;
    w_sum     = w_prod_ext;
    w_cnt_nxt = CNT_WIDTH'(1);
    if (r_state != IDLE) begin
      w_sum     = r_acc + w_prod_ext;
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    end
    w_at_max = (w_cnt_nxt == CNT_WIDTH'(MAX_LEN));
    w_term   = w_accept & (bus.in_last | w_at_max);
    w_out_hs = r_out_valid & bus.out_ready;
  end

  mac_dot_requant #(
    .OUT_WIDTH  (OUT_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .SHIFT      (SHIFT)
  ) u_requant (
    .i_sum  (w_sum),
    .o_data (w_req)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, ACC: begin
        if (w_accept) begin
          w_state_nxt = w_term ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (w_out_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_acc   <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      if (w_accept && !w_term) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_nxt;
      end
      if (w_term) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_req;
        r_out_acc   <= w_sum;
        r_out_beats <= w_cnt_nxt;
        r_out_ovf   <= w_at_max & ~bus.in_last;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mac_dot_stream.md
Name: mac_dot_stream

Overview:
- Streaming dot-product engine that sits on the operand side of the MAC datapath.
- Accepts signed a/b operand beats over a valid/ready handshake, with a last flag marking the end of each vector.
- Accumulates the products at full width, then requantizes the sum back down to DATA_WIDTH, closing the loop from the OUT_WIDTH accumulator domain to the operand domain.
- Presents one result per vector on a valid/ready output. It feeds the next layer or a result buffer.

Parameters:
- DATA_WIDTH, 16: operand width and requantized output width, signed two's complement.
- OUT_WIDTH, 32: accumulator width, signed. Wraps modulo 2^OUT_WIDTH.
- SHIFT, 8: right-shift applied during requantization, 0..OUT_WIDTH-1.
- MAX_LEN, 256: maximum beats per vector before forced termination.
- CNT_WIDTH, 9: beat counter width. Must satisfy 2^CNT_WIDTH > MAX_LEN.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  DATA_WIDTH  signed operand a.
- in_b  in  DATA_WIDTH  signed operand b.
- in_last  in  1  final beat of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_WIDTH  requantized signed result.
- out_acc  out  OUT_WIDTH  raw accumulated sum for the same result.
- out_beats  out  CNT_WIDTH  number of beats accumulated into this result.
- out_ovf  out  1  vector was force-terminated at MAX_LEN without in_last.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - On reset: state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_acc=0, out_beats=0, out_ovf=0.
- States: IDLE, ACC, HOLD.
- in_ready = (state != HOLD). This is a registered-state decode with no combinational path from out_ready.
- Beat acceptance = in_valid & in_ready. For an accepted beat:
  - sum = (state==IDLE ? 0 : acc) + sext(in_a*in_b). The product is a full 2*DATA_WIDTH signed value, sign-extended to OUT_WIDTH; the add wraps modulo 2^OUT_WIDTH.
  - cnt_next = (state==IDLE ? 1 : cnt+1).
- Terminating beat: in_last=1, or cnt_next==MAX_LEN.
  - Registers out_acc=sum, out_beats=cnt_next, out_ovf=(cnt_next==MAX_LEN & ~in_last), and out_data=requant(sum).
  - Sets out_valid=1 and goes to HOLD.
  - Latency: out_valid is high in the cycle after the terminating beat is accepted.
- Non-terminating beat: acc=sum, cnt=cnt_next, state=ACC.
- HOLD:
  - All out_* signals stay stable until out_valid & out_ready.
  - On the output handshake: out_valid=0, state=IDLE. in_ready rises in the following cycle.
  - No beat is accepted in the handshake cycle.
- requant(s):
  - r = (s + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed at OUT_WIDTH+1 bits so the rounding add cannot wrap. This is round-half-up.
  - Narrowing to DATA_WIDTH is controlled by the optional feature.
- Single-beat vector: in_last on the first beat is legal, and out_beats=1.
- With in_valid=0 in ACC, the accumulator holds indefinitely.
- Reset mid-vector or mid-HOLD discards the partial or pending result.
- in_a, in_b and in_last are ignored when in_valid=0.

Optional Feature:
- MAC_DOT_SAT_EN:
  - Defined: r is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] before being written to out_data.
  - Undefined: out_data = r[DATA_WIDTH-1:0], a plain two's-complement truncation.
  - out_acc is identical in both builds.

Decomposition:
- Package mac_dot_pkg holds the state enum (IDLE/ACC/HOLD), the default widths, and a requant rounding-constant function.
- One sub-module, mac_dot_requant: combinational round, shift and saturate/truncate, parameterized by OUT_WIDTH, DATA_WIDTH and SHIFT. It is reused by other blocks that consume the accumulator.
- Multiplier and FSM stay in mac_dot_stream.

Test Plan:
- Beats (100,200), (-50,40, last), out_ready=1 -> one cycle after the last beat: out_acc=18000, out_data=70, out_beats=2, out_ovf=0.
- Rounding: vector (-1,128, last) -> out_acc=-128, out_data=0. Vector (-1,129, last) -> out_acc=-129, out_data=-1.
- Saturation: vector (32767,32767, last) -> out_acc=1073676289. MAC_DOT_SAT_EN defined: out_data=32767. Undefined: out_data=0xFF00 (-256).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> out_* stable and in_ready=0 throughout. Then out_ready=1 -> handshake, and in_ready=1 the next cycle.
- Overrun with MAX_LEN=4: feed 4 beats of (1,1) with in_last=0 -> out_valid with out_acc=4, out_beats=4, out_ovf=1, out_data=0. The next beat starts a fresh vector from acc=0.
- Assert rst after 2 of 3 beats (7,7) -> all outputs 0. Then vector (2,3, last) -> out_acc=6 with no residue from the aborted vector.
